code_seq_detector: RTL and testbench
====================================

Name: code_seq_detector

Overview:
- Parametrised successor to the three-button alarm sequence detector.
- Accepts N one-hot button pulses and compares the entered sequence against a runtime-programmable code of length L on a check pulse.
- Toggles the alarm enable on success and enforces a retry limit with a timed lockout.
- Sits between the debounced button front-end and the alarm controller/LED status logic.

Parameters:
NUM_BUTTONS, 3, number of button inputs (>=2)
CODE_LEN, 3, number of presses in a valid code (>=1)
MAX_TRIES, 3, failed checks allowed before lockout (>=1)
LOCKOUT_CYCLES, 1000, clk cycles spent in LOCKED
TIMEOUT_CYCLES, 1000, idle cycles in ENTRY before the partial entry is discarded
DEFAULT_CODE, 6'b10_01_00, reset code; slot i at bits [i*IDX_W +: IDX_W], slot 0 is the first press (default = b1,b2,b3)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
btn  in  NUM_BUTTONS  button pulses, one clk wide, already debounced; bit k = button k
check  in  1  one-cycle pulse: evaluate the entry
code_wr  in  1  one-cycle pulse: load code_in as the new code
code_in  in  CODE_LEN*IDX_W  new code, same packing as DEFAULT_CODE
seq  out  1  one-cycle pulse: correct code checked
fail  out  1  one-cycle pulse: wrong code checked
enable  out  1  alarm armed level, toggles on each seq
locked  out  1  high while in LOCKED
state_check  out  clog2(CODE_LEN+1)  number of presses accepted in the current entry (saturates at CODE_LEN)
tries_left  out  clog2(MAX_TRIES+1)  remaining attempts

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high.
- Widths: IDX_W = max(1, clog2(NUM_BUTTONS)).
- Reset values: state IDLE, code=DEFAULT_CODE, seq=0, fail=0, enable=0, locked=0, state_check=0, tries_left=MAX_TRIES, mismatch=0, timer=0.
- A rst asserted mid-entry or during LOCKED returns everything to the reset values on the next edge, including restoring the code to DEFAULT_CODE.
- FSM states: IDLE, ENTRY, LOCKED.
- Press (IDLE or ENTRY):
  - A press is any cycle with btn != 0 and check = 0.
  - Valid press: exactly one bit k is set. If state_check < CODE_LEN, compare k against code slot state_check, OR the inequality into mismatch, then increment state_check.
  - If state_check is already CODE_LEN: set mismatch, keep state_check.
  - Multiple bits set: treated as a wrong press; set mismatch, increment state_check (saturating).
  - Any press moves IDLE->ENTRY and clears the timer.
- Check (IDLE or ENTRY):
  - Pass: check=1 with state_check==CODE_LEN and mismatch==0. seq=1 on the next cycle, enable toggles, tries_left=MAX_TRIES.
  - Anything else, including a check in IDLE with no presses: fail=1 on the next cycle and tries_left decrements.
  - If tries_left goes from 1 to 0, go to LOCKED, otherwise go to IDLE.
  - state_check and mismatch clear in both cases.
- Simultaneous check and btn: btn is ignored; check is evaluated on the prior entry.
- Timeout: in ENTRY, the timer counts cycles without a press. When it reaches TIMEOUT_CYCLES-1, go to IDLE and clear state_check and mismatch. No fail pulse; tries_left is unchanged.
- LOCKED:
  - locked=1; btn, check and code_wr are ignored.
  - The timer counts LOCKOUT_CYCLES cycles, then the block goes to IDLE with locked=0 and tries_left=MAX_TRIES.
- code_wr:
  - Accepted only in IDLE with enable=0 (disarmed); takes effect on the next edge.
  - Ignored otherwise; no error flag.
- Latency: all outputs are registered; seq/fail appear exactly 1 cycle after the check sample.

Decomposition:
- Package code_seq_pkg: FSM state enum (IDLE/ENTRY/LOCKED), IDX_W function, and a slot-extract function over the packed code.
- Sub-module cycle_timer: load/clear, count, done at a runtime terminal value. It is shared between TIMEOUT and LOCKOUT, with width clog2(max(TIMEOUT_CYCLES, LOCKOUT_CYCLES)).

Test Plan:
- Correct code, defaults: btn pulses 001,010,100 then check -> state_check 1,2,3; seq=1 one cycle after check; enable 0->1; tries_left=3. Repeat the sequence -> enable 1->0.
- Wrong order: 010,001,100 then check -> fail=1, seq=0, tries_left=2, state_check=0. Extra press (4 presses) then check -> fail, tries_left=1.
- Lockout (bench LOCKOUT_CYCLES=16): three failed checks -> locked=1, tries_left=0. Correct sequence plus check during the lock -> no seq/fail, state_check stays 0. After 16 cycles -> locked=0, tries_left=3.
- Timeout (bench TIMEOUT_CYCLES=20): 001 then 25 idle cycles -> state_check returns to 0, no fail. Then the full correct sequence plus check -> seq.
- Code reprogram: with enable=0, code_wr with code_in=6'b00_10_01 (b2,b3,b1) -> old sequence fails; 010,100,001 then check -> seq, enable=1. Then code_wr with enable=1 -> ignored (b2,b3,b1 still works).
- Corner cases:
  - btn=011 as one press plus two correct presses, then check -> fail.
  - check and btn in the same cycle -> btn ignored.
  - rst mid-entry -> state_check=0, code back to default.

Source files
------------

// File: rtl/code_seq_pkg.sv
// Shared types and helpers for the programmable button-code detector.
package code_seq_pkg;

    // Detector FSM states
    typedef enum logic [1:0] {
        StIdle,
        StEntry,
        StLocked
    } state_e;

    // Upper bound on packed code width accepted by code_slot()
    localparam int unsigned MaxCodeBits = 64;

    // Bits needed to encode one button index (never less than one)
    function automatic int unsigned idx_width(int unsigned num_buttons);
        return (num_buttons <= 2) ? 1 : $clog2(num_buttons);
    endfunction

    // Button index stored in code slot 'slot' of a packed code
    function automatic int unsigned code_slot(logic [MaxCodeBits-1:0] code,
                                              int unsigned slot,
                                              int unsigned idx_w);
        logic [MaxCodeBits-1:0] shifted;
        shifted = code >> (slot * idx_w);
        return 32'(shifted[31:0]) & ((32'd1 << idx_w) - 32'd1);
    endfunction

endpackage

// File: rtl/code_seq_detector_timer.sv
// Up-counter with clear and increment; done flags a runtime terminal count.
module cycle_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_inc,
    input  logic [WIDTH-1:0] i_terminal,
    output logic [WIDTH-1:0] o_count,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    // Count register: clear wins over increment
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_done  = (r_count == i_terminal);

endmodule

// File: rtl/code_seq_detector.sv
// Button-code sequence detector: programmable code, arm toggle, retry limit
// with timed lockout and entry timeout.
module code_seq_detector
    import code_seq_pkg::*;
#(
    parameter int unsigned NUM_BUTTONS    = 3,
    parameter int unsigned CODE_LEN       = 3,
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    localparam int unsigned IDX_W         = idx_width(NUM_BUTTONS),
    parameter logic [CODE_LEN*IDX_W-1:0] DEFAULT_CODE = 6'b10_01_00,
    localparam int unsigned SC_W          = $clog2(CODE_LEN + 1),
    localparam int unsigned TR_W          = $clog2(MAX_TRIES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_BUTTONS-1:0]    btn,
    input  logic                      check,
    input  logic                      code_wr,
    input  logic [CODE_LEN*IDX_W-1:0] code_in,
    output logic                      seq,
    output logic                      fail,
    output logic                      enable,
    output logic                      locked,
    output logic [SC_W-1:0]           state_check,
    output logic [TR_W-1:0]           tries_left
);

    localparam int unsigned MaxCycles = (TIMEOUT_CYCLES > LOCKOUT_CYCLES) ?
                                        TIMEOUT_CYCLES : LOCKOUT_CYCLES;
    localparam int unsigned TMR_W     = (MaxCycles <= 2) ? 1 : $clog2(MaxCycles);

    state_e                    r_state;
    logic [CODE_LEN*IDX_W-1:0] r_code;
    logic [SC_W-1:0]           r_sc;
    logic                      r_mismatch;
    logic [TR_W-1:0]           r_tries;
    logic                      r_seq;
    logic                      r_fail;
    logic                      r_enable;
    logic                      r_locked;

    logic                      w_any_btn;
    logic                      w_one_hot;
    int unsigned               w_btn_idx;
    int unsigned               w_slot;
    logic                      w_press;
    logic                      w_check;
    logic                      w_timer_clear;
    logic                      w_timer_inc;
    logic [TMR_W-1:0]          w_timer_term;
    logic [TMR_W-1:0]          w_timer_count;
    logic                      w_timer_done;

    // Decode the pressed button and fetch the expected slot for this press
    always_comb begin
        w_any_btn = |btn;
        w_one_hot = $onehot(btn);
        w_btn_idx = 0;
        for (int k = 0; k < NUM_BUTTONS; k++) begin
            if (btn[k]) begin
                w_btn_idx = k;
            end
        end
        w_slot = code_slot(MaxCodeBits'(r_code), 32'(r_sc), IDX_W);
    end

    // Timer runs the entry timeout in ENTRY and the lockout in LOCKED
    always_comb begin
        w_press       = w_any_btn && !check && (r_state != StLocked);
        w_check       = check && (r_state != StLocked);
        w_timer_clear = w_press || w_check || (r_state == StIdle) || w_timer_done;
        w_timer_inc   = (r_state == StEntry) || (r_state == StLocked);
        w_timer_term  = (r_state == StLocked) ? TMR_W'(LOCKOUT_CYCLES - 1) :
                                                TMR_W'(TIMEOUT_CYCLES - 1);
    end

    cycle_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_timer_clear),
        .i_inc      (w_timer_inc),
        .i_terminal (w_timer_term),
        .o_count    (w_timer_count),
        .o_done     (w_timer_done)
    );

    // Main FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_code     <= DEFAULT_CODE;
            r_sc       <= '0;
            r_mismatch <= 1'b0;
            r_tries    <= TR_W'(MAX_TRIES);
            r_seq      <= 1'b0;
            r_fail     <= 1'b0;
            r_enable   <= 1'b0;
            r_locked   <= 1'b0;
        end else begin
            r_seq  <= 1'b0;
            r_fail <= 1'b0;
            unique case (r_state)
                StIdle, StEntry: begin
                    if (check) begin
                        // Check takes priority; any same-cycle press is dropped
                        r_sc       <= '0;
                        r_mismatch <= 1'b0;
                        if ((r_sc == SC_W'(CODE_LEN)) && !r_mismatch) begin
                            r_seq    <= 1'b1;
                            r_enable <= !r_enable;
                            r_tries  <= TR_W'(MAX_TRIES);
                            r_state  <= StIdle;
                        end else begin
                            r_fail  <= 1'b1;
                            r_tries <= r_tries - 1'b1;
                            if (r_tries == TR_W'(1)) begin
                                r_state  <= StLocked;
                                r_locked <= 1'b1;
                            end else begin
                                r_state <= StIdle;
                            end
                        end
                    end else if (w_any_btn) begin
                        r_state <= StEntry;
                        if (!w_one_hot) begin
                            r_mismatch <= 1'b1;
                            if (r_sc != SC_W'(CODE_LEN)) begin
                                r_sc <= r_sc + 1'b1;
                            end
                        end else if (r_sc == SC_W'(CODE_LEN)) begin
                            r_mismatch <= 1'b1;
                        end else begin
                            if (w_btn_idx != w_slot) begin
                                r_mismatch <= 1'b1;
                            end
                            r_sc <= r_sc + 1'b1;
                        end
                    end else if ((r_state == StEntry) && w_timer_done) begin
                        r_state    <= StIdle;
                        r_sc       <= '0;
                        r_mismatch <= 1'b0;
                    end
                    // Code may only change while idle and disarmed
                    if ((r_state == StIdle) && code_wr && !r_enable) begin
                        r_code <= code_in;
                    end
                end
                StLocked: begin
                    if (w_timer_done) begin
                        r_state  <= StIdle;
                        r_locked <= 1'b0;
                        r_tries  <= TR_W'(MAX_TRIES);
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign seq         = r_seq;
    assign fail        = r_fail;
    assign enable      = r_enable;
    assign locked      = r_locked;
    assign state_check = r_sc;
    assign tries_left  = r_tries;

    // Count value is only needed for the terminal compare
    logic w_unused;
    assign w_unused = ^w_timer_count;

endmodule

// File: tb/tb_code_seq_detector.sv
// Directed, table-driven bench for code_seq_detector.
module tb_code_seq_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] btn;
    logic       check;
    logic       code_wr;
    logic [5:0] code_in;
    logic       seq;
    logic       fail;
    logic       enable;
    logic       locked;
    logic [1:0] state_check;
    logic [1:0] tries_left;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      name;
        logic       rst;
        logic [2:0] btn;
        logic       chk;
        logic       wr;
        logic [5:0] code;
        logic       e_seq;
        logic       e_fail;
        logic       e_en;
        logic       e_lk;
        logic [1:0] e_sc;
        logic [1:0] e_tr;
    } vec_t;

    vec_t vecs[$];

    code_seq_detector #(
        .NUM_BUTTONS    (3),
        .CODE_LEN       (3),
        .MAX_TRIES      (3),
        .LOCKOUT_CYCLES (16),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn         (btn),
        .check       (check),
        .code_wr     (code_wr),
        .code_in     (code_in),
        .seq         (seq),
        .fail        (fail),
        .enable      (enable),
        .locked      (locked),
        .state_check (state_check),
        .tries_left  (tries_left)
    );

    always #5 clk = ~clk;

    task automatic add(input string nm, input logic r, input logic [2:0] b, input logic c,
                       input logic w, input logic [5:0] cd, input logic s, input logic f,
                       input logic e, input logic l, input logic [1:0] sc,
                       input logic [1:0] tr);
        vec_t v;
        v.name = nm; v.rst = r; v.btn = b; v.chk = c; v.wr = w; v.code = cd;
        v.e_seq = s; v.e_fail = f; v.e_en = e; v.e_lk = l; v.e_sc = sc; v.e_tr = tr;
        vecs.push_back(v);
    endtask

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample all outputs 1 time unit after the edge
    task automatic step(input logic r, input logic [2:0] b, input logic c, input logic w,
                        input logic [5:0] cd);
        rst = r; btn = b; check = c; code_wr = w; code_in = cd;
        @(posedge clk);
        #1;
        rst = 1'b0; btn = 3'b000; check = 1'b0; code_wr = 1'b0; code_in = 6'b0;
    endtask

    function automatic logic [7:0] outs();
        return {seq, fail, enable, locked, state_check, tries_left};
    endfunction

    initial begin
        rst = 1'b1; btn = 3'b000; check = 1'b0; code_wr = 1'b0; code_in = 6'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cmp("reset", 32'(outs()), 32'({1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd3}));

        // Correct default code, twice: enable toggles on and off
        add("a1", 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 1, 3);
        add("a2", 0, 3'b010, 0, 0, 0, 0, 0, 0, 0, 2, 3);
        add("a3", 0, 3'b100, 0, 0, 0, 0, 0, 0, 0, 3, 3);
        add("a_chk", 0, 3'b000, 1, 0, 0, 1, 0, 1, 0, 0, 3);
        add("a_idle", 0, 3'b000, 0, 0, 0, 0, 0, 1, 0, 0, 3);
        add("b1", 0, 3'b001, 0, 0, 0, 0, 0, 1, 0, 1, 3);
        add("b2", 0, 3'b010, 0, 0, 0, 0, 0, 1, 0, 2, 3);
        add("b3", 0, 3'b100, 0, 0, 0, 0, 0, 1, 0, 3, 3);
        add("b_chk", 0, 3'b000, 1, 0, 0, 1, 0, 0, 0, 0, 3);
        add("b_idle", 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        // Wrong order
        add("c1", 0, 3'b010, 0, 0, 0, 0, 0, 0, 0, 1, 3);
        add("c2", 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 2, 3);
        add("c3", 0, 3'b100, 0, 0, 0, 0, 0, 0, 0, 3, 3);
        add("c_chk", 0, 3'b000, 1, 0, 0, 0, 1, 0, 0, 0, 2);
        // Extra fourth press saturates the count
        add("d1", 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        add("d2", 0, 3'b010, 0, 0, 0, 0, 0, 0, 0, 2, 2);
        add("d3", 0, 3'b100, 0, 0, 0, 0, 0, 0, 0, 3, 2);
        add("d4", 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 3, 2);
        add("d_chk", 0, 3'b000, 1, 0, 0, 0, 1, 0, 0, 0, 1);
        // Empty check in IDLE exhausts the last try
        add("e_chk", 0, 3'b000, 1, 0, 0, 0, 1, 0, 1, 0, 0);
        // Inputs ignored while locked
        add("f1", 0, 3'b001, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        add("f2", 0, 3'b010, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        add("f3", 0, 3'b100, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        add("f_chk", 0, 3'b000, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 5; i <= 15; i++)
            add($sformatf("f_lock%0d", i), 0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        add("f_release", 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        // Entry timeout after 20 idle cycles
        add("g_p", 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 1, 3);
        for (int i = 1; i <= 19; i++)
            add($sformatf("g_wait%0d", i), 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 3);
        for (int i = 20; i <= 25; i++)
            add($sformatf("g_tmo%0d", i), 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        add("g1", 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 1, 3);
        add("g2", 0, 3'b010, 0, 0, 0, 0, 0, 0, 0, 2, 3);
        add("g3", 0, 3'b100, 0, 0, 0, 0, 0, 0, 0, 3, 3);
        add("g_chk", 0, 3'b000, 1, 0, 0, 1, 0, 1, 0, 0, 3);
        // code_wr while armed is ignored: default code still works
        add("h_wr", 0, 3'b000, 0, 1, 6'b001001, 0, 0, 1, 0, 0, 3);
        add("h1", 0, 3'b001, 0, 0, 0, 0, 0, 1, 0, 1, 3);
        add("h2", 0, 3'b010, 0, 0, 0, 0, 0, 1, 0, 2, 3);
        add("h3", 0, 3'b100, 0, 0, 0, 0, 0, 1, 0, 3, 3);
        add("h_chk", 0, 3'b000, 1, 0, 0, 1, 0, 0, 0, 0, 3);
        // Reprogram to b2,b3,b1 while disarmed
        add("i_wr", 0, 3'b000, 0, 1, 6'b001001, 0, 0, 0, 0, 0, 3);
        add("i1", 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 1, 3);
        add("i2", 0, 3'b010, 0, 0, 0, 0, 0, 0, 0, 2, 3);
        add("i3", 0, 3'b100, 0, 0, 0, 0, 0, 0, 0, 3, 3);
        add("i_old_chk", 0, 3'b000, 1, 0, 0, 0, 1, 0, 0, 0, 2);
        add("i4", 0, 3'b010, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        add("i5", 0, 3'b100, 0, 0, 0, 0, 0, 0, 0, 2, 2);
        add("i6", 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 3, 2);
        add("i_new_chk", 0, 3'b000, 1, 0, 0, 1, 0, 1, 0, 0, 3);
        // Armed: writing the default back is ignored
        add("j_wr", 0, 3'b000, 0, 1, 6'b100100, 0, 0, 1, 0, 0, 3);
        add("j1", 0, 3'b010, 0, 0, 0, 0, 0, 1, 0, 1, 3);
        add("j2", 0, 3'b100, 0, 0, 0, 0, 0, 1, 0, 2, 3);
        add("j3", 0, 3'b001, 0, 0, 0, 0, 0, 1, 0, 3, 3);
        add("j_chk", 0, 3'b000, 1, 0, 0, 1, 0, 0, 0, 0, 3);
        // Multi-bit press counts as a wrong press
        add("k1", 0, 3'b011, 0, 0, 0, 0, 0, 0, 0, 1, 3);
        add("k2", 0, 3'b100, 0, 0, 0, 0, 0, 0, 0, 2, 3);
        add("k3", 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 3, 3);
        add("k_chk", 0, 3'b000, 1, 0, 0, 0, 1, 0, 0, 0, 2);
        // btn alongside check is dropped
        add("l1", 0, 3'b010, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        add("l2", 0, 3'b100, 0, 0, 0, 0, 0, 0, 0, 2, 2);
        add("l3", 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 3, 2);
        add("l_chk_btn", 0, 3'b001, 1, 0, 0, 1, 0, 1, 0, 0, 3);
        add("l_idle", 0, 3'b000, 0, 0, 0, 0, 0, 1, 0, 0, 3);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].btn, vecs[i].chk, vecs[i].wr, vecs[i].code);
            cmp(vecs[i].name, 32'(outs()),
                32'({vecs[i].e_seq, vecs[i].e_fail, vecs[i].e_en, vecs[i].e_lk,
                     vecs[i].e_sc, vecs[i].e_tr}));
        end

        // rst mid-entry with a reprogrammed code restores the default code
        step(0, 3'b001, 0, 0, 0);  // code is b2,b3,b1 here: wrong press, count 1
        step(0, 3'b010, 0, 0, 0);
        cmp("m_entry_sc", 32'(state_check), 32'd2);
        step(1, 3'b000, 0, 0, 0);
        cmp("m_rst_sc", 32'(state_check), 32'd0);
        cmp("m_rst_en", 32'(enable), 32'd0);
        cmp("m_rst_tr", 32'(tries_left), 32'd3);
        step(0, 3'b001, 0, 0, 0);
        step(0, 3'b010, 0, 0, 0);
        step(0, 3'b100, 0, 0, 0);
        cmp("m_sc3", 32'(state_check), 32'd3);
        step(0, 3'b000, 1, 0, 0);
        cmp("m_seq", 32'({seq, fail, enable}), 32'(3'b101));
        step(0, 3'b000, 0, 0, 0);
        cmp("m_seq_pulse_end", 32'({seq, fail, enable}), 32'(3'b001));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
